// File: rtl/doa_pkg.sv
// Shared types, constants and FSM encoding for the DOA top-K judge.
// Latency: n/a (declarations only). Backpressure: n/a.
package doa_pkg;

    localparam int DOA_SPEC_W  = 48;
    localparam int DOA_ANGLE_W = 10;

    typedef logic signed [DOA_SPEC_W-1:0] spec_t;
    typedef logic [DOA_ANGLE_W-1:0]       angle_t;

    localparam spec_t DOA_SPEC_MAX = {1'b0, {(DOA_SPEC_W-1){1'b1}}};

    typedef enum logic [2:0] {
        IDLE,
        COLLECT,
        FLUSH,
        INSERT_LAST,
        DONE
    } doa_state_e;

    // Sample-history depth saturates at 2: only v[n-1] and v[n-2] matter.
    function automatic logic [1:0] hist_inc(input logic [1:0] n);
        return (n == 2'd2) ? n : n + 2'd1;
    endfunction

endpackage

// File: rtl/doa_topk_insert.sv
// NUM_SRC-deep list sorted by ascending signed value; ties keep the older entry first.
// Latency: one cycle per insert (parallel compare, then shift). Backpressure: none, accepts every cycle.
module doa_topk_insert #(
    parameter  int DOASEARCH_WIDTH = 48,
    parameter  int ANGLE_WIDTH     = 10,
    parameter  int NUM_SRC         = 4,
    localparam int CNT_W           = $clog2(NUM_SRC + 1)
) (
    input  logic                              iclk,
    input  logic                              irst,
    input  logic                              iclr,
    input  logic                              iins,
    input  logic signed [DOASEARCH_WIDTH-1:0] ival,
    input  logic        [ANGLE_WIDTH-1:0]     iang,
    output logic        [ANGLE_WIDTH-1:0]     oangle [0:NUM_SRC-1],
    output logic signed [DOASEARCH_WIDTH-1:0] ovalue [0:NUM_SRC-1],
    output logic        [CNT_W-1:0]           ocount
);

    localparam logic signed [DOASEARCH_WIDTH-1:0] VAL_MAX = {1'b0, {(DOASEARCH_WIDTH-1){1'b1}}};

    logic [NUM_SRC-1:0] vld_q;
    logic [NUM_SRC-1:0] le;
    logic [NUM_SRC-1:0] prev_le;
    logic [NUM_SRC-1:0] nxt_vld;
    logic signed [DOASEARCH_WIDTH-1:0] nxt_val [0:NUM_SRC-1];
    logic        [ANGLE_WIDTH-1:0]     nxt_ang [0:NUM_SRC-1];

    // le is a prefix mask: entries that stay ahead of the new candidate.
    always_comb begin
        le = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            le[i] = vld_q[i] && (ovalue[i] <= ival);
        end
    end

    always_comb begin
        prev_le = '1;
        for (int i = 1; i < NUM_SRC; i++) begin
            prev_le[i] = le[i-1];
        end
    end

    always_comb begin
        nxt_vld = vld_q;
        nxt_val = ovalue;
        nxt_ang = oangle;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (!le[i] && prev_le[i]) begin
                nxt_vld[i] = 1'b1;
                nxt_val[i] = ival;
                nxt_ang[i] = iang;
            end
        end
        for (int i = 1; i < NUM_SRC; i++) begin
            if (!le[i] && !prev_le[i]) begin
                nxt_vld[i] = vld_q[i-1];
                nxt_val[i] = ovalue[i-1];
                nxt_ang[i] = oangle[i-1];
            end
        end
    end

    // A candidate no better than a full list's tail leaves le all-ones and is dropped.
    always_ff @(posedge iclk) begin
        if (irst || iclr) begin
            vld_q  <= '0;
            ocount <= '0;
            for (int i = 0; i < NUM_SRC; i++) begin
                ovalue[i] <= VAL_MAX;
                oangle[i] <= '0;
            end
        end else if (iins && !le[NUM_SRC-1]) begin
            vld_q  <= nxt_vld;
            ovalue <= nxt_val;
            oangle <= nxt_ang;
            if (!vld_q[NUM_SRC-1]) begin
                ocount <= ocount + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/doa_topk_judge.sv
// Scans a DOA pseudo-spectrum, keeps the NUM_SRC deepest local minima (DOA_JUDGE_THRESH_EN adds ithresh).
// Latency: odone three cycles after the ilast handshake. Backpressure: oready high only while collecting.
module doa_topk_judge
    import doa_pkg::*;
#(
    parameter  int DOASEARCH_WIDTH = 48,
    parameter  int ANGLE_WIDTH     = 10,
    parameter  int NUM_SRC         = 4,
    localparam int CNT_W           = $clog2(NUM_SRC + 1)
) (
    input  logic                              iclk,
    input  logic                              irst,
    input  logic                              istart,
    input  logic                              ivalid,
    output logic                              oready,
    input  logic signed [DOASEARCH_WIDTH-1:0] ispec,
    input  logic        [ANGLE_WIDTH-1:0]     iangle,
    input  logic                              ilast,
`ifdef DOA_JUDGE_THRESH_EN
    input  logic signed [DOASEARCH_WIDTH-1:0] ithresh,
`endif
    output logic        [ANGLE_WIDTH-1:0]     oangle [0:NUM_SRC-1],
    output logic signed [DOASEARCH_WIDTH-1:0] ovalue [0:NUM_SRC-1],
    output logic        [CNT_W-1:0]           ocount,
    output logic                              odone,
    output logic                              obusy
);

    doa_state_e state_q;

    logic signed [DOASEARCH_WIDTH-1:0] cur_val;
    logic signed [DOASEARCH_WIDTH-1:0] prev_val;
    logic        [ANGLE_WIDTH-1:0]     cur_ang;
    logic        [1:0]                 nsamp;
    logic                              cand_vld;
    logic signed [DOASEARCH_WIDTH-1:0] cand_val;
    logic        [ANGLE_WIDTH-1:0]     cand_ang;
    logic                              cur_pass;
    logic                              accept;
    logic                              list_clr;

`ifdef DOA_JUDGE_THRESH_EN
    logic signed [DOASEARCH_WIDTH-1:0] thresh_q;
    assign cur_pass = (cur_val <= thresh_q);
`else
    assign cur_pass = 1'b1;
`endif

    assign accept   = ivalid && oready;
    assign list_clr = (state_q == IDLE) && istart;

    // cur is judged once its right neighbour arrives; the verdict is inserted the following cycle.
    always_ff @(posedge iclk) begin
        if (irst) begin
            state_q  <= IDLE;
            oready   <= 1'b0;
            obusy    <= 1'b0;
            odone    <= 1'b0;
            cand_vld <= 1'b0;
            cand_val <= '0;
            cand_ang <= '0;
            cur_val  <= '0;
            prev_val <= '0;
            cur_ang  <= '0;
            nsamp    <= '0;
`ifdef DOA_JUDGE_THRESH_EN
            thresh_q <= '0;
`endif
        end else begin
            odone    <= 1'b0;
            cand_vld <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (istart) begin
                        state_q <= COLLECT;
                        oready  <= 1'b1;
                        obusy   <= 1'b1;
                        nsamp   <= '0;
`ifdef DOA_JUDGE_THRESH_EN
                        thresh_q <= ithresh;
`endif
                    end
                end
                COLLECT: begin
                    if (accept) begin
                        prev_val <= cur_val;
                        cur_val  <= ispec;
                        cur_ang  <= iangle;
                        nsamp    <= hist_inc(nsamp);
                        cand_val <= cur_val;
                        cand_ang <= cur_ang;
                        if (nsamp == 2'd1) begin
                            cand_vld <= cur_pass && (cur_val <= ispec);
                        end else if (nsamp == 2'd2) begin
                            cand_vld <= cur_pass && (cur_val < prev_val) && (cur_val <= ispec);
                        end
                        if (ilast) begin
                            state_q <= FLUSH;
                            oready  <= 1'b0;
                        end
                    end
                end
                FLUSH: begin
                    // Endpoint: a lone sample always qualifies, otherwise it must dip below its left neighbour.
                    cand_val <= cur_val;
                    cand_ang <= cur_ang;
                    cand_vld <= cur_pass && ((nsamp == 2'd1) || (cur_val < prev_val));
                    state_q  <= INSERT_LAST;
                end
                INSERT_LAST: begin
                    state_q <= DONE;
                    odone   <= 1'b1;
                end
                DONE: begin
                    state_q <= IDLE;
                    obusy   <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    oready  <= 1'b0;
                    obusy   <= 1'b0;
                end
            endcase
        end
    end

    doa_topk_insert #(
        .DOASEARCH_WIDTH (DOASEARCH_WIDTH),
        .ANGLE_WIDTH     (ANGLE_WIDTH),
        .NUM_SRC         (NUM_SRC)
    ) u_list (
        .iclk   (iclk),
        .irst   (irst),
        .iclr   (list_clr),
        .iins   (cand_vld),
        .ival   (cand_val),
        .iang   (cand_ang),
        .oangle (oangle),
        .ovalue (ovalue),
        .ocount (ocount)
    );

endmodule

// File: tb/tb_doa_topk_judge.sv
// Directed bench for doa_topk_judge: NUM_SRC=4 and NUM_SRC=2 instances share one stimulus stream.
module tb_doa_topk_judge;

    localparam int W  = 48;
    localparam int AW = 10;
    localparam logic [63:0] MAXV = 64'h0000_7FFF_FFFF_FFFF;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst;
    logic                istart;
    logic                ivalid;
    logic                ilast;
    logic signed [W-1:0] ispec;
    logic [AW-1:0]       iangle;
`ifdef DOA_JUDGE_THRESH_EN
    logic signed [W-1:0] ithresh;
`endif

    logic                rdy4, done4, busy4;
    logic [AW-1:0]       ang4 [0:3];
    logic signed [W-1:0] val4 [0:3];
    logic [2:0]          cnt4;

    logic                rdy2, done2, busy2;
    logic [AW-1:0]       ang2 [0:1];
    logic signed [W-1:0] val2 [0:1];
    logic [1:0]          cnt2;

    int checks = 0;
    int errors = 0;

    int sv [0:15];
    int sa [0:15];
    int slen;

    doa_topk_judge #(.DOASEARCH_WIDTH(W), .ANGLE_WIDTH(AW), .NUM_SRC(4)) dut4 (
        .iclk(clk), .irst(rst), .istart(istart), .ivalid(ivalid), .oready(rdy4),
        .ispec(ispec), .iangle(iangle), .ilast(ilast),
`ifdef DOA_JUDGE_THRESH_EN
        .ithresh(ithresh),
`endif
        .oangle(ang4), .ovalue(val4), .ocount(cnt4), .odone(done4), .obusy(busy4)
    );

    doa_topk_judge #(.DOASEARCH_WIDTH(W), .ANGLE_WIDTH(AW), .NUM_SRC(2)) dut2 (
        .iclk(clk), .irst(rst), .istart(istart), .ivalid(ivalid), .oready(rdy2),
        .ispec(ispec), .iangle(iangle), .ilast(ilast),
`ifdef DOA_JUDGE_THRESH_EN
        .ithresh(ithresh),
`endif
        .oangle(ang2), .ovalue(val2), .ocount(cnt2), .odone(done2), .obusy(busy2)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_scan(input bit gaps, input bit busy_start);
        int g;
        logic o1, o2, o3, o4;
        g = 0;
        while (busy4 && g < 100) begin
            tick();
            g++;
        end
        chk("idle_before_start", 64'(busy4), 64'd0);
        istart = 1'b1;
        tick();
        istart = 1'b0;
        for (int i = 0; i < slen; i++) begin
            if (gaps) repeat ($urandom_range(0, 3)) tick();
            ivalid = 1'b1;
            ispec  = W'(sv[i]);
            iangle = AW'(sa[i]);
            ilast  = (i == slen - 1);
            if (busy_start && i == 2) istart = 1'b1;
            g = 0;
            while (!rdy4 && g < 20) begin
                tick();
                g++;
            end
            chk("oready_wait", 64'(rdy4), 64'd1);
            tick();
            istart = 1'b0;
            ivalid = 1'b0;
            ilast  = 1'b0;
        end
        o1 = done4;
        tick();
        o2 = done4;
        tick();
        o3 = done4;
        tick();
        o4 = done4;
        chk("odone_latency", 64'({o1, o2, o3, o4}), 64'b0010);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        int seen;
        rst = 1'b1; istart = 1'b0; ivalid = 1'b0; ilast = 1'b0;
        ispec = '0; iangle = '0;
`ifdef DOA_JUDGE_THRESH_EN
        ithresh = W'(MAXV);
`endif
        repeat (3) tick();

        chk("rst_busy",  64'(busy4), 64'd0);
        chk("rst_ready", 64'(rdy4),  64'd0);
        chk("rst_done",  64'(done4), 64'd0);
        chk("rst_count", 64'(cnt4),  64'd0);
        for (int i = 0; i < 4; i++) begin
            chk("rst_angle", 64'(ang4[i]), 64'd0);
            chk("rst_value", 64'(val4[i]), MAXV);
        end
        rst = 1'b0;
        tick();

        // Minima 5@10, 3@30, 2@50; a stray istart mid-scan must be ignored.
        slen = 7;
        sv[0:6] = '{9, 5, 7, 3, 8, 2, 6};
        for (int i = 0; i < 7; i++) sa[i] = 10 * i;
        run_scan(1'b0, 1'b1);
        chk("a_count", 64'(cnt4), 64'd3);
        chk("a_ang0", 64'(ang4[0]), 64'd50);
        chk("a_ang1", 64'(ang4[1]), 64'd30);
        chk("a_ang2", 64'(ang4[2]), 64'd10);
        chk("a_val0", 64'(val4[0]), 64'd2);
        chk("a_val1", 64'(val4[1]), 64'd3);
        chk("a_val2", 64'(val4[2]), 64'd5);
        chk("a_ang3_empty", 64'(ang4[3]), 64'd0);
        chk("a_val3_empty", 64'(val4[3]), MAXV);
        chk("a2_count", 64'(cnt2), 64'd2);
        chk("a2_ang0", 64'(ang2[0]), 64'd50);
        chk("a2_ang1", 64'(ang2[1]), 64'd30);
        repeat (4) tick();
        chk("a_hold_count", 64'(cnt4), 64'd3);
        chk("a_hold_ang0", 64'(ang4[0]), 64'd50);
        chk("a_hold_busy", 64'(busy4), 64'd0);

        // Same data with random ivalid gaps.
        run_scan(1'b1, 1'b0);
        chk("ag_count", 64'(cnt4), 64'd3);
        chk("ag_ang0", 64'(ang4[0]), 64'd50);
        chk("ag_ang1", 64'(ang4[1]), 64'd30);
        chk("ag_ang2", 64'(ang4[2]), 64'd10);

        // Six minima 6,1,5,2,4,3 at angles 10,30,..,110.
        slen = 13;
        sv[0:12] = '{9, 6, 9, 1, 9, 5, 9, 2, 9, 4, 9, 3, 9};
        for (int i = 0; i < 13; i++) sa[i] = 10 * i;
        run_scan(1'b0, 1'b0);
        chk("b2_count", 64'(cnt2), 64'd2);
        chk("b2_ang0", 64'(ang2[0]), 64'd30);
        chk("b2_ang1", 64'(ang2[1]), 64'd70);
        chk("b2_val0", 64'(val2[0]), 64'd1);
        chk("b2_val1", 64'(val2[1]), 64'd2);
        chk("b4_count_sat", 64'(cnt4), 64'd4);
        chk("b4_ang2", 64'(ang4[2]), 64'd110);
        chk("b4_ang3", 64'(ang4[3]), 64'd90);
        chk("b4_val3", 64'(val4[3]), 64'd4);

        // Plateau: only the first 3 is taken.
        slen = 5;
        sv[0:4] = '{5, 3, 3, 3, 6};
        for (int i = 0; i < 5; i++) sa[i] = 10 * i;
        run_scan(1'b0, 1'b0);
        chk("c_count", 64'(cnt4), 64'd1);
        chk("c_ang0", 64'(ang4[0]), 64'd10);
        chk("c_val0", 64'(val4[0]), 64'd3);
        chk("c_ang1_empty", 64'(ang4[1]), 64'd0);
        chk("c_val1_empty", 64'(val4[1]), MAXV);

        // Single negative sample, with and without gaps.
        slen = 1;
        sv[0] = -7;
        sa[0] = 45;
        for (int r = 0; r < 2; r++) begin
            run_scan(r == 1, 1'b0);
            chk("d_count", 64'(cnt4), 64'd1);
            chk("d_ang0", 64'(ang4[0]), 64'd45);
            chk("d_val0", 64'(val4[0]), -64'sd7);
        end

        // Reset mid-scan, with istart and ivalid also high in the reset cycle.
        istart = 1'b1;
        tick();
        istart = 1'b0;
        ivalid = 1'b1; ispec = W'(8); iangle = AW'(200);
        tick();
        ispec = W'(2); iangle = AW'(210);
        tick();
        rst = 1'b1; istart = 1'b1; ispec = W'(5);
        tick();
        chk("e_rst_busy", 64'(busy4), 64'd0);
        chk("e_rst_ready", 64'(rdy4), 64'd0);
        chk("e_rst_count", 64'(cnt4), 64'd0);
        chk("e_rst_val0", 64'(val4[0]), MAXV);
        rst = 1'b0; istart = 1'b0; ivalid = 1'b0;
        seen = 0;
        repeat (6) begin
            tick();
            seen = seen | int'(done4);
        end
        chk("e_no_done", 64'(seen), 64'd0);
        slen = 3;
        sv[0:2] = '{4, 1, 4};
        sa[0:2] = '{100, 110, 120};
        run_scan(1'b0, 1'b0);
        chk("e_count", 64'(cnt4), 64'd1);
        chk("e_ang0", 64'(ang4[0]), 64'd110);
        chk("e_val0", 64'(val4[0]), 64'd1);

`ifdef DOA_JUDGE_THRESH_EN
        ithresh = W'(2);
        slen = 7;
        sv[0:6] = '{9, 5, 7, 3, 8, 2, 6};
        for (int i = 0; i < 7; i++) sa[i] = 10 * i;
        run_scan(1'b0, 1'b1);
        ithresh = W'(MAXV);
        chk("t_count", 64'(cnt4), 64'd1);
        chk("t_ang0", 64'(ang4[0]), 64'd50);
        chk("t_val0", 64'(val4[0]), 64'd2);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
